// File: rtl/ice_uart_if.sv
// ice_uart_if: byte-level handshake between the ICE UART and its client
// (the command parser on the board, or a system bench acting as host).
interface ice_uart_if;
    logic       tx_latch;
    logic [7:0] tx_data;
    logic       tx_empty;
    logic       rx_latch;
    logic [7:0] rx_data;

    // Client side: loads bytes to send, consumes received bytes
    modport master (
        output tx_latch,
        output tx_data,
        input  tx_empty,
        input  rx_latch,
        input  rx_data
    );

    // UART side
    modport slave (
        input  tx_latch,
        input  tx_data,
        output tx_empty,
        output rx_latch,
        output rx_data
    );
endinterface

// File: rtl/ice_uart.sv
// ice_uart: 8N1 LSB-first full-duplex UART with a runtime bit period
// (baud_div clock cycles per bit). TX and RX are independent FSMs.
module ice_uart (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] baud_div,
    input  logic        rx_in,
    output logic        tx_out,
    ice_uart_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Last count value of a full bit period and of a half bit period
    logic [15:0] bit_end_s;
    logic [15:0] half_end_s;

    assign bit_end_s  = baud_div - 16'd1;
    assign half_end_s = {1'b0, baud_div[15:1]} - 16'd1;

    state_t      tx_state_r;
    logic [15:0] tx_cnt_r;
    logic [2:0]  tx_bit_r;
    logic [7:0]  tx_shift_r;
    logic        tx_out_r;
    logic        tx_empty_r;

    state_t      rx_state_r;
    logic [15:0] rx_cnt_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_shift_r;
    logic [7:0]  rx_data_r;
    logic        rx_latch_r;
    logic        rx_wait_high_r;
    logic        rx_meta_r;
    logic        rx_sync_r;

    assign tx_out       = tx_out_r;
    assign bus.tx_empty = tx_empty_r;
    assign bus.rx_latch = rx_latch_r;
    assign bus.rx_data  = rx_data_r;

    // Transmit FSM: start bit, 8 data bits LSB first, stop bit; all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_out_r   <= 1'b1;
            tx_empty_r <= 1'b1;
        end else begin
            case (tx_state_r)
                ST_IDLE: begin
                    if (bus.tx_latch) begin
                        tx_shift_r <= bus.tx_data;
                        tx_cnt_r   <= 16'd0;
                        tx_bit_r   <= 3'd0;
                        tx_out_r   <= 1'b0;
                        tx_empty_r <= 1'b0;
                        tx_state_r <= ST_START;
                    end else begin
                        tx_out_r   <= 1'b1;
                        tx_empty_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tx_cnt_r == bit_end_s) begin
                        tx_cnt_r   <= 16'd0;
                        tx_out_r   <= tx_shift_r[0];
                        tx_state_r <= ST_DATA;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt_r == bit_end_s) begin
                        tx_cnt_r <= 16'd0;
                        if (tx_bit_r == 3'd7) begin
                            tx_out_r   <= 1'b1;
                            tx_state_r <= ST_STOP;
                        end else begin
                            tx_bit_r   <= tx_bit_r + 3'd1;
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                            tx_out_r   <= tx_shift_r[1];
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 16'd1;
                    end
                end
                ST_STOP: begin
                    // tx_empty rises on the edge that ends the stop bit
                    if (tx_cnt_r == bit_end_s) begin
                        tx_cnt_r   <= 16'd0;
                        tx_empty_r <= 1'b1;
                        tx_state_r <= ST_IDLE;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 16'd1;
                    end
                end
                default: begin
                    tx_state_r <= ST_IDLE;
                    tx_out_r   <= 1'b1;
                    tx_empty_r <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous serial input (idles high)
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_in;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive FSM: verify start at half bit, then sample each bit centre
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_r     <= ST_IDLE;
            rx_cnt_r       <= 16'd0;
            rx_bit_r       <= 3'd0;
            rx_shift_r     <= 8'h00;
            rx_data_r      <= 8'h00;
            rx_latch_r     <= 1'b0;
            rx_wait_high_r <= 1'b0;
        end else begin
            rx_latch_r <= 1'b0;
            case (rx_state_r)
                ST_IDLE: begin
                    // After a framing error the line must return high first
                    if (rx_wait_high_r) begin
                        if (rx_sync_r) begin
                            rx_wait_high_r <= 1'b0;
                        end
                    end else if (!rx_sync_r) begin
                        rx_cnt_r   <= 16'd0;
                        rx_state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt_r == half_end_s) begin
                        rx_cnt_r <= 16'd0;
                        if (rx_sync_r) begin
                            rx_state_r <= ST_IDLE;
                        end else begin
                            rx_bit_r   <= 3'd0;
                            rx_state_r <= ST_DATA;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_r == bit_end_s) begin
                        rx_cnt_r   <= 16'd0;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= ST_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt_r == bit_end_s) begin
                        rx_cnt_r   <= 16'd0;
                        rx_state_r <= ST_IDLE;
                        if (rx_sync_r) begin
                            rx_data_r  <= rx_shift_r;
                            rx_latch_r <= 1'b1;
                        end else begin
                            rx_wait_high_r <= 1'b1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                default: begin
                    rx_state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ice_uart.sv
// tb_ice_uart: directed bench for ice_uart with a byte scoreboard; covers
// reset, loopback, back-to-back stream, glitch, framing error, ignored
// mid-frame load and mid-frame reset.
module tb_ice_uart;

    logic        clk;
    logic        reset;
    logic [15:0] baud_div;
    logic        rx_in;
    logic        rx_drv;
    logic        loop_en;
    logic        tx_out;

    ice_uart_if bus ();

    ice_uart dut (
        .clk      (clk),
        .reset    (reset),
        .baud_div (baud_div),
        .rx_in    (rx_in),
        .tx_out   (tx_out),
        .bus      (bus)
    );

    assign rx_in = loop_en ? tx_out : rx_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         latch_cnt = 0;
    int         last_latch_cyc = 0;
    int         fall_cnt = 0;
    int         start_cyc = 0;
    logic       prev_tx = 1'b1;
    logic [7:0] rx_log [0:63];
    logic [7:0] exp_q [$];

    // Cycle counter for latency measurements
    always @(posedge clk) cyc = cyc + 1;

    // Output monitor: log received bytes and count tx_out falling edges
    always @(negedge clk) begin
        if (bus.rx_latch === 1'b1) begin
            if (latch_cnt < 64) rx_log[latch_cnt] = bus.rx_data;
            latch_cnt = latch_cnt + 1;
            last_latch_cyc = cyc;
        end
        if (prev_tx === 1'b1 && tx_out === 1'b0) fall_cnt = fall_cnt + 1;
        prev_tx = tx_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Number of 1->0 transitions on the line for one frame from idle-high
    function automatic int frame_falls(input logic [7:0] b);
        logic [9:0] f;
        logic       prev;
        int         n;
        f = {1'b1, b, 1'b0};
        prev = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (prev && !f[i]) n++;
            prev = f[i];
        end
        return n;
    endfunction

    // Wait (bounded) for tx_empty, then load one byte for a single cycle
    task automatic send_byte(input logic [7:0] b, input bit expect_rx);
        int guard;
        guard = 0;
        while (bus.tx_empty !== 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("tx_ready_in_time", {31'd0, guard < 3000}, 32'd1);
        bus.tx_data  = b;
        bus.tx_latch = 1'b1;
        start_cyc    = cyc + 1;
        if (expect_rx) exp_q.push_back(b);
        @(negedge clk);
        bus.tx_latch = 1'b0;
    endtask

    // Count cycles tx_empty stays low; optionally pulse tx_latch at poke_at
    task automatic measure_tx_low(input int poke_at, input logic [7:0] poke_byte, output int n);
        n = 0;
        while (bus.tx_empty === 1'b0 && n < 2000) begin
            n++;
            if (n == poke_at) begin
                bus.tx_data  = poke_byte;
                bus.tx_latch = 1'b1;
            end else begin
                bus.tx_latch = 1'b0;
            end
            @(negedge clk);
        end
        bus.tx_latch = 1'b0;
    endtask

    // Bit-bang one frame on rx_drv with the given stop-bit level
    task automatic drive_frame(input logic [7:0] b, input logic stop);
        int bd;
        bd = int'(baud_div);
        rx_drv = 1'b0;
        repeat (bd) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (bd) @(negedge clk);
        end
        rx_drv = stop;
        repeat (bd) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    // Compare received bytes since base against the scoreboard
    task automatic check_rx(input int base, input int count, input string tag);
        logic [7:0] e;
        check({tag, "_count"}, latch_cnt - base, count);
        for (int i = 0; i < count; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check(tag, {24'd0, rx_log[(base + i) % 64]}, {24'd0, e});
        end
    endtask

    logic [7:0] stream [0:4];
    int         base;
    int         f0;
    int         n;
    int         lat;
    int         exp_falls;

    initial begin
        reset        = 1'b1;
        baud_div     = 16'd10;
        loop_en      = 1'b0;
        rx_drv       = 1'b1;
        bus.tx_latch = 1'b0;
        bus.tx_data  = 8'h00;
        stream[0] = 8'h6d; stream[1] = 8'h0f; stream[2] = 8'h02;
        stream[3] = 8'h72; stream[4] = 8'h01;

        // Reset state
        repeat (10) @(negedge clk);
        check("rst_tx_out",   {31'd0, tx_out},       32'd1);
        check("rst_tx_empty", {31'd0, bus.tx_empty}, 32'd1);
        check("rst_rx_latch", {31'd0, bus.rx_latch}, 32'd0);
        check("rst_rx_data",  {24'd0, bus.rx_data},  32'h00);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Loopback single byte, frame length and receive latency
        loop_en = 1'b1;
        base = latch_cnt;
        send_byte(8'h6d, 1'b1);
        measure_tx_low(-1, 8'h00, n);
        check("tx_empty_low_6d", n, 100);
        repeat (20) @(negedge clk);
        lat = last_latch_cyc - start_cyc;
        check("rx_latency_96_98", {31'd0, (lat >= 96 && lat <= 98)}, 32'd1);
        check_rx(base, 1, "loop_6d");

        // Back-to-back stream at full rate
        base = latch_cnt;
        f0 = fall_cnt;
        exp_falls = 0;
        for (int i = 0; i < 5; i++) begin
            send_byte(stream[i], 1'b1);
            exp_falls += frame_falls(stream[i]);
        end
        measure_tx_low(-1, 8'h00, n);
        repeat (20) @(negedge clk);
        check("stream_falls", fall_cnt - f0, exp_falls);
        check_rx(base, 5, "stream");

        // 0x00 frame: a single falling edge
        base = latch_cnt;
        f0 = fall_cnt;
        send_byte(8'h00, 1'b1);
        measure_tx_low(-1, 8'h00, n);
        repeat (20) @(negedge clk);
        check("zero_falls", fall_cnt - f0, 1);
        check_rx(base, 1, "zero");

        // Short glitch must not start a reception
        loop_en = 1'b0;
        rx_drv = 1'b1;
        repeat (5) @(negedge clk);
        base = latch_cnt;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_no_latch", latch_cnt - base, 0);
        exp_q.push_back(8'ha5);
        drive_frame(8'ha5, 1'b1);
        repeat (20) @(negedge clk);
        check_rx(base, 1, "after_glitch");

        // Framing error: byte dropped, rx_data held, next frame fine
        base = latch_cnt;
        drive_frame(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        check("frame_err_no_latch", latch_cnt - base, 0);
        check("frame_err_rx_data", {24'd0, bus.rx_data}, 32'ha5);
        exp_q.push_back(8'h3c);
        drive_frame(8'h3c, 1'b1);
        repeat (20) @(negedge clk);
        check_rx(base, 1, "after_frame_err");

        // tx_latch mid-frame with another byte is ignored
        loop_en = 1'b1;
        repeat (5) @(negedge clk);
        base = latch_cnt;
        send_byte(8'h81, 1'b1);
        measure_tx_low(35, 8'h7e, n);
        check("tx_empty_low_midload", n, 100);
        repeat (20) @(negedge clk);
        check_rx(base, 1, "midload");

        // Reset mid-frame aborts both paths
        base = latch_cnt;
        send_byte(8'h33, 1'b0);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tx_out",   {31'd0, tx_out},       32'd1);
        check("midrst_tx_empty", {31'd0, bus.tx_empty}, 32'd1);
        reset = 1'b0;
        repeat (150) @(negedge clk);
        check("midrst_no_latch", latch_cnt - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ice_uart.md
# ice_uart

Byte-wide asynchronous serial transceiver (8 data bits, no parity, 1 stop bit, LSB first) with a runtime-programmable bit period. It connects the ICE host link (USB UART pins) to the ICE command parser inside the top-level ICE design, and is reused as the host-side stimulus model in system benches. Transmit and receive paths are independent and full-duplex.

## Interface
Parameters:
- none (bit period is the `baud_div` input)

Ports:
- clk  in  1  system clock (20 MHz in the ICE board)
- reset  in  1  synchronous, active-high reset
- baud_div  in  16  clock cycles per serial bit; legal range 4..65535; sampled continuously, change only while both paths idle
- rx_in  in  1  serial input, idle high, asynchronous to clk
- tx_out  out  1  serial output, idle high
- rx_latch  out  1  one-cycle pulse: rx_data holds a newly received byte
- rx_data  out  8  last received byte; stable until the next rx_latch
- tx_latch  in  1  load strobe; tx_data captured on the cycle it is high while idle
- tx_data  in  8  byte to transmit
- tx_empty  out  1  high = transmitter idle, ready for tx_latch

## Operation
- Reset (clk edge with reset=1): tx_out=1, tx_empty=1, rx_latch=0, rx_data=8'h00, both FSMs to IDLE, counters cleared.
- TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - IDLE: tx_out=1, tx_empty=1. On tx_latch=1: capture tx_data into shift register, go START.
  - START: tx_out=0 for baud_div cycles.
  - DATA: tx_out=shift[0], shift right every baud_div cycles, 8 bits.
  - STOP: tx_out=1 for baud_div cycles, then IDLE.
  - tx_latch while not IDLE is ignored (no queueing, no corruption of current frame).
- RX path: rx_in passes through a 2-flop synchronizer; all logic uses the synchronized value.
- RX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - IDLE: wait for synchronized rx_in = 0.
  - START: after baud_div/2 (integer divide) cycles, resample; if 1, treat as glitch and return to IDLE; else go DATA.
  - DATA: sample every baud_div cycles at bit centre, shift in LSB first, 8 samples.
  - STOP: sample after baud_div cycles; if 1, load rx_data and pulse rx_latch for exactly one cycle; if 0 (framing error), discard byte, leave rx_data unchanged, no pulse. Then IDLE. After a framing error, IDLE additionally waits for rx_in=1 before accepting a new start edge.
- Bit-period counter: 16-bit down/up counter compared against baud_div (or baud_div/2); no wrap issues within the legal range.

## Timing
- tx_empty falls on the clk edge that samples tx_latch=1 (visible the following cycle); tx_out goes low on that same edge.
- A frame occupies exactly 10*baud_div cycles from the tx_out falling edge to tx_empty rising; tx_empty rises on the same edge that ends the stop bit. A new tx_latch on the first cycle tx_empty=1 starts the next frame immediately (back-to-back at full rate).
- rx_latch asserts 2 + baud_div/2 + 9*baud_div cycles (±1) after the rx_in falling edge of the start bit, i.e. mid stop bit; rx_data is valid on the same cycle and held afterwards.
- Receiver tolerates ±3% bit-rate mismatch, and back-to-back frames with zero idle time between them.
- Reset asserted mid-frame aborts both paths on the next edge: tx_out returns to 1, no rx_latch for the partial frame.

## Test plan
- Reset check: hold reset 10 cycles -> tx_out=1, tx_empty=1, rx_latch=0, rx_data=00.
- Loopback (tx_out->rx_in), baud_div=10, send 0x6d -> tx_empty low exactly 100 cycles; one rx_latch pulse of width 1 with rx_data=0x6d ~97 cycles after the start bit.
- Back-to-back stream 6d 0f 02 72 01 (next tx_latch on first tx_empty=1 cycle) -> exactly 5 rx_latch pulses, bytes in order; tx_out falling-edge count matches the bit pattern (0x00 frame yields exactly 1 falling edge).
- Glitch: drive rx_in low for 3 cycles, baud_div=10 -> no rx_latch, receiver accepts a valid 0xa5 frame immediately afterwards.
- Framing error: frame 0x55 with stop bit forced low -> no rx_latch, rx_data keeps the previous value; next valid frame received correctly after the line returns high.
- tx_latch pulsed mid-frame with a different byte -> ignored; received byte equals the original, tx_empty timing unchanged.
